// File: rtl/dds_pkg.sv
// Definitions shared by the DDS generators and the tuning-word meter.
package dds_pkg;

  // Tuning-word width, identical to the DDS phase accumulators.
  localparam int STEP_W = 32;

  localparam logic [15:0] MID_DEFAULT = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DIVIDE  = 3'd3,
    ST_DONE    = 3'd4
  } meter_state_e;

endpackage

// File: rtl/step_divider.sv
// Restoring divider: quotient = 2^(STEP_W+EXP) / divisor, one bit per clock, MSB first.
// The caller guarantees divisor > 2^EXP so the quotient fits in STEP_W bits.
module step_divider
  import dds_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int EXP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIV_W-1:0]  divisor,
  output logic              done,
  output logic [STEP_W-1:0] quotient
);

  localparam int RW = DIV_W + 1;
  localparam int BW = $clog2(STEP_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(STEP_W - 1);

  logic [DIV_W-1:0]  div_reg;
  logic [RW-1:0]     rem_reg;
  logic [RW-1:0]     rem_next;
  logic [RW-1:0]     rem_shift;
  logic [STEP_W-1:0] quo_reg;
  logic [STEP_W-1:0] quo_next;
  logic [BW-1:0]     bit_reg;
  logic              run_reg;
  logic              fits;

  // Dividend bits below 2^STEP_W are all zero, so each step only doubles the remainder.
  always_comb begin
    rem_shift = {rem_reg[RW-2:0], 1'b0};
    fits      = rem_reg[RW-1] | (rem_shift >= {1'b0, div_reg});
    rem_next  = fits ? (rem_shift - {1'b0, div_reg}) : rem_shift;
    quo_next  = {quo_reg[STEP_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_reg <= 1'b0;
      bit_reg <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      div_reg <= '0;
    end else if (start) begin
      run_reg <= 1'b1;
      bit_reg <= '0;
      rem_reg <= RW'(1) << EXP;
      quo_reg <= '0;
      div_reg <= divisor;
    end else if (run_reg) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      bit_reg <= bit_reg + 1'b1;
      if (bit_reg == LAST_BIT) begin
        run_reg <= 1'b0;
      end
    end
  end

  // Combinational so the caller can step to its result state on the final bit's edge.
  assign done     = run_reg && (bit_reg == LAST_BIT);
  assign quotient = quo_reg;

endmodule

// File: rtl/tuning_word_meter.sv
// Measures the period of a 16-bit sample stream over 2^NCYC_LOG2 midscale crossings
// and converts it into the DDS tuning word that would regenerate that frequency.
module tuning_word_meter
  import dds_pkg::*;
#(
  parameter int          NCYC_LOG2 = 4,
  parameter int          CNT_W     = 24,
  parameter logic [15:0] HYST      = 16'd256,
  parameter logic [15:0] MID       = MID_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       sample_in,
  output logic [STEP_W-1:0] step_out,
  output logic              step_valid,
  output logic              timeout,
  output logic              busy
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] ARM     = ST_ARM;
  localparam logic [2:0] MEASURE = ST_MEASURE;
  localparam logic [2:0] DIVIDE  = ST_DIVIDE;
  localparam logic [2:0] DONE    = ST_DONE;

  localparam int                NC_W        = NCYC_LOG2 + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  N_CNT       = CNT_W'(2 ** NCYC_LOG2);
  localparam logic [NC_W-1:0]   NCROSS_LAST = NC_W'(2 ** NCYC_LOG2 - 1);
  localparam logic [15:0]       ARM_LEVEL   = MID - HYST;

  logic [15:0]       s_q;
  logic              armed_reg;
  logic              crossing;
  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  wait_reg, wait_next;
  logic [NC_W-1:0]   ncross_reg, ncross_next;
  logic [STEP_W-1:0] result_reg, result_next;
  logic              from_div_reg, from_div_next;
  logic              tmo_reg, tmo_next;
  logic              div_start;
  logic              div_done;
  logic [STEP_W-1:0] div_q;

  assign crossing = armed_reg && (s_q >= MID);
  assign busy     = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wait_next     = wait_reg;
    ncross_next   = ncross_reg;
    result_next   = result_reg;
    from_div_next = from_div_reg;
    tmo_next      = tmo_reg;
    div_start     = 1'b0;
    case (state_reg)
      IDLE: begin
        wait_next = '0;
        if (enable) begin
          state_next = ARM;
        end
      end
      ARM: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (crossing) begin
          state_next  = MEASURE;
          cnt_next    = CNT_W'(1);
          ncross_next = '0;
        end else if (wait_reg == CNT_MAX) begin
          result_next   = '0;
          from_div_next = 1'b0;
          tmo_next      = 1'b1;
          state_next    = DONE;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      MEASURE: begin
        // Limit is checked before counting so cnt never wraps.
        if (cnt_reg == CNT_MAX) begin
          result_next   = '0;
          from_div_next = 1'b0;
          tmo_next      = 1'b1;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (crossing) begin
            ncross_next = ncross_reg + 1'b1;
            if (ncross_reg == NCROSS_LAST) begin
              tmo_next = 1'b0;
              if (cnt_reg <= N_CNT) begin
                // Input at or above clk rate: quotient would not fit.
                result_next   = '1;
                from_div_next = 1'b0;
                state_next    = DONE;
              end else begin
                div_start     = 1'b1;
                from_div_next = 1'b1;
                state_next    = DIVIDE;
              end
            end
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        wait_next  = '0;
        state_next = enable ? ARM : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Midscale neither arms nor crosses, so a high input after reset is not a crossing.
      s_q          <= MID;
      armed_reg    <= 1'b0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wait_reg     <= '0;
      ncross_reg   <= '0;
      result_reg   <= '0;
      from_div_reg <= 1'b0;
      tmo_reg      <= 1'b0;
      step_out     <= '0;
      step_valid   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      s_q <= sample_in;
      if (crossing) begin
        armed_reg <= 1'b0;
      end else if (s_q < ARM_LEVEL) begin
        armed_reg <= 1'b1;
      end
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wait_reg     <= wait_next;
      ncross_reg   <= ncross_next;
      result_reg   <= result_next;
      from_div_reg <= from_div_next;
      tmo_reg      <= tmo_next;
      step_valid   <= (state_reg == DONE);
      if (state_reg == DONE) begin
        step_out <= from_div_reg ? div_q : result_reg;
        timeout  <= tmo_reg;
      end
    end
  end

  step_divider #(
    .DIV_W (CNT_W),
    .EXP   (NCYC_LOG2)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .divisor  (cnt_reg),
    .done     (div_done),
    .quotient (div_q)
  );

endmodule

// File: tb/tb_tuning_word_meter.sv
// Directed sequence with random square waves and noise; expected tuning words come
// from 2^(32+NCYC_LOG2) / (N * period) and result spacing from the period alone.
module tb_tuning_word_meter;

  localparam int NCYC = 4;
  localparam int N    = 2 ** NCYC;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        enable_to;
  logic        to_const;
  logic [15:0] sample_in;
  logic [15:0] sample_to;
  logic [31:0] step_out, step_out_to;
  logic        step_valid, step_valid_to;
  logic        timeout, timeout_to;
  logic        busy, busy_to;

  int n_pass  = 0;
  int n_total = 0;

  // waveform generator state
  int          gen_mode = 0;
  logic [31:0] ph = '0;
  logic [31:0] gen_step = '0;
  bit          noise = 1'b0;
  int          sq_p = 2, sq_h = 1, sq_idx = 0;
  logic [15:0] sq_lo = 16'h0000, sq_hi = 16'hFFFF;

  assign sample_to = to_const ? 16'h9000 : sample_in;

  tuning_word_meter #(
    .NCYC_LOG2 (NCYC), .CNT_W (24), .HYST (16'd256), .MID (16'h8000)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .sample_in (sample_in),
    .step_out (step_out), .step_valid (step_valid), .timeout (timeout), .busy (busy)
  );

  tuning_word_meter #(
    .NCYC_LOG2 (NCYC), .CNT_W (12), .HYST (16'd256), .MID (16'h8000)
  ) dut_to (
    .clk (clk), .reset (reset), .enable (enable_to), .sample_in (sample_to),
    .step_out (step_out_to), .step_valid (step_valid_to), .timeout (timeout_to), .busy (busy_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tri_of(input logic [31:0] p);
    return p[31] ? ~p[30:15] : p[30:15];
  endfunction

  function automatic longint exp_step(input int t);
    return (longint'(1) << (32 + NCYC)) / longint'(t);
  endfunction

  // Next start is the first crossing at least 34 clocks after the previous end crossing.
  function automatic int exp_interval(input int p);
    return (N + (34 + p - 1) / p) * p;
  endfunction

  task automatic tick();
    int v;
    @(posedge clk);
    #1;
    if (gen_mode == 0) begin
      ph = ph + gen_step;
      v = int'(tri_of(ph));
      if (noise) v = v + int'($urandom_range(400)) - 200;
      if (v < 0) v = 0;
      else if (v > 65535) v = 65535;
    end else begin
      sq_idx = (sq_idx + 1 >= sq_p) ? 0 : sq_idx + 1;
      v = (sq_idx < sq_h) ? int'(sq_lo) : int'(sq_hi);
    end
    sample_in = v[15:0];
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int which, input int limit, input string tag, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < limit) begin
      tick();
      n++;
      got = (which == 1) ? step_valid_to : step_valid;
    end
    n_total++;
    assert (got === 1'b1) n_pass++;
    else $error("FAIL %s no step_valid within %0d clocks observed=0 expected=1", tag, limit);
    $display("%s: step_out=%08h timeout=%0b after %0d clocks", tag,
             (which == 1) ? step_out_to : step_out, (which == 1) ? timeout_to : timeout, n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    longint qa, qb, prev, cur, d;
    int p;

    reset = 1'b0; enable = 1'b0; enable_to = 1'b0; to_const = 1'b0;
    sample_in = 16'h8000;

    // Triangle, Step = 0x01000000 -> period 256, T = 4096
    gen_mode = 0; gen_step = 32'h0100_0000; ph = 32'h0080_0000; noise = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst step_out", longint'(step_out), 0);
    check("rst step_valid", longint'(step_valid), 0);
    check("rst timeout", longint'(timeout), 0);
    check("rst busy", longint'(busy), 0);
    enable = 1'b1;
    wait_valid(0, 12000, "tri256 #1", n);
    check("tri256 #1 step", longint'(step_out), exp_step(N * 256));
    check("tri256 #1 timeout", longint'(timeout), 0);
    wait_valid(0, 12000, "tri256 #2", n);
    check("tri256 #2 step", longint'(step_out), exp_step(N * 256));
    check("tri256 interval", longint'(n), longint'(exp_interval(256)));

    // Reset in the middle of the divide (about bit 10), then a clean result
    repeat (4329) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("middiv step_out", longint'(step_out), 0);
    check("middiv step_valid", longint'(step_valid), 0);
    check("middiv timeout", longint'(timeout), 0);
    check("middiv busy", longint'(busy), 0);
    wait_valid(0, 12000, "after middiv", n);
    check("after middiv step", longint'(step_out), exp_step(N * 256));

    // Step = 0x00C00000 -> period 341.33, T is 5461 or 5462
    gen_step = 32'h00C0_0000; ph = '0;
    do_reset();
    qa = exp_step(5461);
    qb = exp_step(5462);
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      wait_valid(0, 15000, "tri341", n);
      cur = longint'(step_out);
      check("tri341 step in {T=5461,5462}", longint'(cur == qa || cur == qb), 1);
      if (r > 0) begin
        d = (cur > prev) ? cur - prev : prev - cur;
        check("tri341 consecutive spread", longint'(d <= qa - qb), 1);
      end
      prev = cur;
    end

    // Noisy triangle: +-200 LSB noise must not add crossings
    gen_step = 32'h0100_0000; ph = 32'h0080_0000; noise = 1'b1;
    do_reset();
    wait_valid(0, 12000, "noisy #1", n);
    check("noisy #1 step", longint'(step_out), exp_step(N * 256));
    wait_valid(0, 12000, "noisy #2", n);
    check("noisy #2 step", longint'(step_out), exp_step(N * 256));
    noise = 1'b0;

    // Square toggling every clock: T = 32, step = 0x80000000
    gen_mode = 1; sq_p = 2; sq_h = 1; sq_idx = 0; sq_lo = 16'h0000; sq_hi = 16'hFFFF;
    do_reset();
    wait_valid(0, 500, "sq2 #1", n);
    check("sq2 #1 step", longint'(step_out), exp_step(N * 2));
    wait_valid(0, 500, "sq2 #2", n);
    check("sq2 #2 step", longint'(step_out), exp_step(N * 2));
    check("sq2 interval", longint'(n), longint'(exp_interval(2)));

    // enable falls mid-measurement: result still arrives, then idle
    repeat (5) tick();
    enable = 1'b0;
    wait_valid(0, 200, "sq2 enable-off", n);
    check("enable-off step", longint'(step_out), exp_step(N * 2));
    check("enable-off busy", longint'(busy), 0);
    enable = 1'b1;

    // Random square waves
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(40, 2));
      sq_p = p; sq_h = int'($urandom_range(p - 1, 1)); sq_idx = 0;
      sq_lo = 16'($urandom_range(16'h7EFF, 0));
      sq_hi = 16'($urandom_range(16'hFFFF, 16'h8000));
      $display("random square: period=%0d high_from=%0d lo=%04h hi=%04h", p, sq_h, sq_lo, sq_hi);
      do_reset();
      wait_valid(0, 3000, "rsq #1", n);
      check("rsq #1 step", longint'(step_out), exp_step(N * p));
      wait_valid(0, 3000, "rsq #2", n);
      check("rsq #2 step", longint'(step_out), exp_step(N * p));
      check("rsq interval", longint'(n), longint'(exp_interval(p)));
    end

    // ARM timeout on the CNT_W=12 instance with a constant above midscale
    enable = 1'b0;
    to_const = 1'b1;
    do_reset();
    enable_to = 1'b1;
    wait_valid(1, 5000, "arm timeout", n);
    check("arm timeout flag", longint'(timeout_to), 1);
    check("arm timeout step", longint'(step_out_to), 0);
    check("arm timeout latency 4094..4100", longint'(n >= 4094 && n <= 4100), 1);
    to_const = 1'b0;
    gen_mode = 0; gen_step = 32'h0200_0000; ph = 32'h0080_0000;
    wait_valid(1, 8000, "recover tri128", n);
    check("recover step", longint'(step_out_to), exp_step(N * 128));
    check("recover timeout cleared", longint'(timeout_to), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
